matmul_apb_master: RTL and testbench
====================================

// Module: matmul_apb_master
// PURPOSE
//  APB initiator that drives the matmul accelerator's APB slave port (psel/penable/pwrite/pstrb/pwdata/paddr).
//  Converts a valid/ready command stream into single APB transfers and returns a response (rdata, slverr, timeout).
//  Sits between a host/sequencer and the matmul DUT; optionally holds off writes while busy_i is high.
// PARAMETERS
//  BUS_WIDTH   64  APB data width (bits); pstrb width = BUS_WIDTH/8
//  ADDR_WIDTH  32  APB address width (bits)
//  MAX_WAIT    16  max ACCESS cycles with pready_i low before abort; 0 = no timeout
//  BUSY_GATE   1   1: writes are not accepted while busy_i=1; 0: ignore busy_i
// PORTS
//  clk_i          in   1             clock, all logic on rising edge
//  rst_i          in   1             synchronous, active-high reset
//  cmd_valid_i    in   1             command request
//  cmd_ready_o    out  1             command accepted when valid&ready
//  cmd_write_i    in   1             1=write, 0=read
//  cmd_addr_i     in   ADDR_WIDTH    target address
//  cmd_wdata_i    in   BUS_WIDTH     write data
//  cmd_strb_i     in   BUS_WIDTH/8   write byte strobes
//  rsp_valid_o    out  1             response available
//  rsp_ready_i    in   1             response consumed when valid&ready
//  rsp_rdata_o    out  BUS_WIDTH     read data (0 for writes/timeouts)
//  rsp_err_o      out  1             pslverr_i sampled at completion, or timeout
//  rsp_timeout_o  out  1             transfer aborted by MAX_WAIT
//  psel_o         out  1             APB select
//  penable_o      out  1             APB enable
//  pwrite_o       out  1             APB direction
//  pstrb_o        out  BUS_WIDTH/8   APB strobes (0 on reads)
//  pwdata_o       out  BUS_WIDTH     APB write data (0 on reads)
//  paddr_o        out  ADDR_WIDTH    APB address
//  pready_i       in   1             APB ready from slave
//  pslverr_i      in   1             APB error from slave
//  prdata_i       in   BUS_WIDTH     APB read data
//  busy_i         in   1             accelerator busy flag
// BEHAVIOUR
//  Reset: all outputs 0 (incl. cmd_ready_o, rsp_*), state IDLE, wait counter 0.
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  IDLE: cmd_ready_o=1 unless (BUSY_GATE && busy_i && cmd_write_i). On accept: register cmd fields, drive APB bus, go SETUP.
//  SETUP (1 cycle): psel_o=1, penable_o=0. Always -> ACCESS.
//  ACCESS: psel_o=1, penable_o=1; paddr/pwrite/pwdata/pstrb stable throughout.
//   pready_i=1 -> capture prdata_i (reads only), pslverr_i -> RESP; psel/penable drop the next cycle.
//   pready_i=0 -> wait counter +1; counter==MAX_WAIT (MAX_WAIT>0) -> abort: psel/penable drop, rsp_err_o=1,
//   rsp_timeout_o=1, rdata 0 -> RESP.
//  RESP: rsp_valid_o=1 and fields held until rsp_ready_i=1 -> IDLE; cmd_ready_o=0 while not IDLE.
//  Latency: accept edge T, SETUP T+1, ACCESS T+2, pready at T+2 -> rsp_valid_o at T+3. Min 4 cycles/transfer.
//  Reads drive pstrb_o=0 and pwdata_o=0; bus fields return to 0 in IDLE/RESP.
//  busy_i is sampled only in IDLE; busy change mid-transfer has no effect. Reads are never gated.
//  Wait counter: $clog2(MAX_WAIT+1) bits, cleared on entering SETUP; no wrap (saturates at abort).
//  rst_i mid-transfer: next edge forces IDLE, APB outputs 0, pending response discarded.
//  pslverr_i is ignored except in the ACCESS cycle where pready_i=1.
// STRUCTURE
//  matmul_pkg: apb_mst_state_e {IDLE,SETUP,ACCESS,RESP}; defaults for BUS_WIDTH/ADDR_WIDTH/MAX_WAIT.
//  Single module; the wait counter is inline. No sub-module.
// TESTING
//  Write addr 0x10 data 0xDEAD_BEEF strb 0xFF, pready tied 1 -> psel T+1, penable T+2, rsp_valid T+3, err 0.
//  Read addr 0x20, pready low 3 cycles, prdata 0x1234 -> ACCESS held 4 cycles, fields stable, rsp_rdata 0x1234.
//  MAX_WAIT=4, pready stuck 0 -> abort after 4 wait cycles, rsp_err=1, rsp_timeout=1, psel drops.
//  busy_i=1, write pending -> cmd_ready_o=0; read accepted; busy_i->0 -> write accepted next cycle.
//  pslverr_i=1 with pready -> rsp_err=1, timeout=0; rsp_ready_i low 5 cycles -> rsp held, no new cmd.
//  rst_i asserted in ACCESS -> next edge psel/penable/rsp_valid=0, IDLE; the next command runs normally.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and default widths for the matmul accelerator's APB initiator.
package matmul_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } apb_mst_state_e;

  localparam int unsigned DefBusWidth  = 64;
  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefMaxWait   = 16;

endpackage

// File: rtl/matmul_apb_master.sv
// APB initiator: turns a valid/ready command stream into single APB transfers and
// returns a response with read data, slave error and timeout status.
module matmul_apb_master
  import matmul_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = DefBusWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned MAX_WAIT   = DefMaxWait,
  parameter int unsigned BUSY_GATE  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]   cmd_wdata_i,
  input  logic [BUS_WIDTH/8-1:0] cmd_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [BUS_WIDTH-1:0]   rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic                   rsp_timeout_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [BUS_WIDTH/8-1:0] pstrb_o,
  output logic [BUS_WIDTH-1:0]   pwdata_o,
  output logic [ADDR_WIDTH-1:0]  paddr_o,
  input  logic                   pready_i,
  input  logic                   pslverr_i,
  input  logic [BUS_WIDTH-1:0]   prdata_i,
  input  logic                   busy_i
);

  localparam int unsigned StrbW = BUS_WIDTH / 8;
  localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  apb_mst_state_e r_state, w_state_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [BUS_WIDTH-1:0]  r_wdata;
  logic [StrbW-1:0]      r_strb;
  logic [BUS_WIDTH-1:0]  r_rdata;
  logic                  r_err;
  logic                  r_timeout;
  logic [WaitW-1:0]      r_wait_cnt;

  logic w_write_gated;
  logic w_accept;
  logic w_bus_active;
  logic w_timeout_hit;

  assign w_write_gated = (BUSY_GATE != 0) && busy_i && cmd_write_i;
  assign cmd_ready_o   = (r_state == StIdle) && !rst_i && !w_write_gated;
  assign w_accept      = cmd_valid_i && cmd_ready_o;
  assign w_bus_active  = (r_state == StSetup) || (r_state == StAccess);

  // Fires on the MAX_WAIT-th ACCESS cycle that sees pready_i low.
  assign w_timeout_hit = (MAX_WAIT != 0) &&
                         (({1'b0, r_wait_cnt} + 1'b1) == (WaitW + 1)'(MAX_WAIT));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_next = StSetup;
      StSetup:  w_state_next = StAccess;
      StAccess: if (pready_i || w_timeout_hit) w_state_next = StResp;
      StResp:   if (rsp_ready_i) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_strb     <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_addr     <= cmd_addr_i;
            r_write    <= cmd_write_i;
            r_wdata    <= cmd_write_i ? cmd_wdata_i : '0;
            r_strb     <= cmd_write_i ? cmd_strb_i : '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= '0;
          end
        end
        StAccess: begin
          if (pready_i) begin
            r_rdata <= r_write ? '0 : prdata_i;
            r_err   <= pslverr_i;
          end else begin
            if (MAX_WAIT != 0) r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_timeout_hit) begin
              r_err     <= 1'b1;
              r_timeout <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign psel_o        = w_bus_active;
  assign penable_o     = (r_state == StAccess);
  assign pwrite_o      = w_bus_active && r_write;
  assign paddr_o       = w_bus_active ? r_addr : '0;
  assign pwdata_o      = w_bus_active ? r_wdata : '0;
  assign pstrb_o       = w_bus_active ? r_strb : '0;
  assign rsp_valid_o   = (r_state == StResp);
  assign rsp_rdata_o   = rsp_valid_o ? r_rdata : '0;
  assign rsp_err_o     = rsp_valid_o && r_err;
  assign rsp_timeout_o = rsp_valid_o && r_timeout;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed bench for matmul_apb_master: write, waited read, timeout, busy gating,
// slave error with response backpressure, and reset mid-transfer.
module tb_matmul_apb_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [63:0] cmd_wdata_i;
  logic [7:0]  cmd_strb_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [7:0]  pstrb_o;
  logic [63:0] pwdata_o;
  logic [31:0] paddr_o;
  logic        pready_i, pslverr_i;
  logic [63:0] prdata_i;
  logic        busy_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  matmul_apb_master #(
    .BUS_WIDTH (64),
    .ADDR_WIDTH(32),
    .MAX_WAIT  (4),
    .BUSY_GATE (1)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .cmd_strb_i   (cmd_strb_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .pstrb_o      (pstrb_o),
    .pwdata_o     (pwdata_o),
    .paddr_o      (paddr_o),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i),
    .prdata_i     (prdata_i),
    .busy_i       (busy_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                           input logic [7:0] strb);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;
    cmd_strb_i  = strb;
  endtask

  task automatic drop_cmd();
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    cmd_strb_i  = '0;
  endtask

  task automatic consume_rsp();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    rst_i     = 1'b1;
    drop_cmd();
    rsp_ready_i = 1'b0;
    pready_i  = 1'b1;
    pslverr_i = 1'b0;
    prdata_i  = '0;
    busy_i    = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_psel", psel_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_paddr", paddr_o, 0);
    rst_i = 1'b0;
    #1;
    chk("idle_cmd_ready", cmd_ready_o, 1);

    // Write, zero wait states.
    drive_cmd(1'b1, 32'h10, 64'hDEAD_BEEF, 8'hFF);
    tick();
    drop_cmd();
    chk("wr_setup_psel", psel_o, 1);
    chk("wr_setup_penable", penable_o, 0);
    chk("wr_setup_pwrite", pwrite_o, 1);
    chk("wr_setup_paddr", paddr_o, 64'h10);
    chk("wr_setup_pwdata", pwdata_o, 64'hDEAD_BEEF);
    chk("wr_setup_pstrb", pstrb_o, 8'hFF);
    chk("wr_setup_cmd_ready", cmd_ready_o, 0);
    tick();
    chk("wr_access_psel", psel_o, 1);
    chk("wr_access_penable", penable_o, 1);
    tick();
    chk("wr_rsp_valid", rsp_valid_o, 1);
    chk("wr_rsp_err", rsp_err_o, 0);
    chk("wr_rsp_rdata", rsp_rdata_o, 0);
    chk("wr_rsp_psel", psel_o, 0);
    chk("wr_rsp_paddr", paddr_o, 0);
    consume_rsp();
    chk("wr_done_rsp_valid", rsp_valid_o, 0);
    chk("wr_done_cmd_ready", cmd_ready_o, 1);

    // Read with three wait states.
    pready_i = 1'b0;
    drive_cmd(1'b0, 32'h20, 64'h5555, 8'hAA);
    tick();
    drop_cmd();
    chk("rd_setup_pstrb", pstrb_o, 0);
    chk("rd_setup_pwdata", pwdata_o, 0);
    chk("rd_setup_pwrite", pwrite_o, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_penable", penable_o, 1);
      chk("rd_wait_paddr", paddr_o, 64'h20);
      chk("rd_wait_rsp_valid", rsp_valid_o, 0);
      tick();
    end
    pready_i = 1'b1;
    prdata_i = 64'h1234;
    chk("rd_last_penable", penable_o, 1);
    tick();
    prdata_i = '0;
    chk("rd_rsp_valid", rsp_valid_o, 1);
    chk("rd_rsp_rdata", rsp_rdata_o, 64'h1234);
    chk("rd_rsp_err", rsp_err_o, 0);
    chk("rd_rsp_timeout", rsp_timeout_o, 0);
    consume_rsp();

    // Timeout: pready stuck low, abort after four wait cycles.
    pready_i = 1'b0;
    drive_cmd(1'b1, 32'h30, 64'h77, 8'h0F);
    tick();
    drop_cmd();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_penable", penable_o, 1);
      tick();
    end
    chk("to_rsp_valid", rsp_valid_o, 1);
    chk("to_rsp_err", rsp_err_o, 1);
    chk("to_rsp_timeout", rsp_timeout_o, 1);
    chk("to_rsp_rdata", rsp_rdata_o, 0);
    chk("to_psel", psel_o, 0);
    chk("to_penable", penable_o, 0);
    consume_rsp();
    pready_i = 1'b1;

    // Busy gating: writes held off, reads pass.
    busy_i = 1'b1;
    drive_cmd(1'b1, 32'h48, 64'h99, 8'hFF);
    #1;
    chk("busy_wr_ready", cmd_ready_o, 0);
    tick();
    chk("busy_wr_not_taken", psel_o, 0);
    drive_cmd(1'b0, 32'h40, 64'h0, 8'h0);
    #1;
    chk("busy_rd_ready", cmd_ready_o, 1);
    tick();
    drop_cmd();
    chk("busy_rd_psel", psel_o, 1);
    chk("busy_rd_pwrite", pwrite_o, 0);
    tick();
    tick();
    chk("busy_rd_rsp_valid", rsp_valid_o, 1);
    consume_rsp();
    drive_cmd(1'b1, 32'h48, 64'h99, 8'hFF);
    #1;
    chk("busy_still_ready", cmd_ready_o, 0);
    busy_i = 1'b0;
    #1;
    chk("unbusy_ready", cmd_ready_o, 1);
    tick();
    drop_cmd();
    chk("unbusy_wr_psel", psel_o, 1);
    chk("unbusy_wr_pwrite", pwrite_o, 1);
    chk("unbusy_wr_paddr", paddr_o, 64'h48);
    tick();
    tick();
    consume_rsp();

    // Slave error plus response backpressure.
    pslverr_i = 1'b1;
    drive_cmd(1'b1, 32'h50, 64'h1, 8'h01);
    tick();
    drive_cmd(1'b0, 32'h58, 64'h0, 8'h0);
    tick();
    tick();
    pslverr_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("err_rsp_valid", rsp_valid_o, 1);
      chk("err_rsp_err", rsp_err_o, 1);
      chk("err_rsp_timeout", rsp_timeout_o, 0);
      chk("err_cmd_ready", cmd_ready_o, 0);
      chk("err_psel", psel_o, 0);
      tick();
    end
    drop_cmd();
    consume_rsp();
    chk("err_done_rsp_valid", rsp_valid_o, 0);
    chk("err_done_cmd_ready", cmd_ready_o, 1);

    // Reset while in ACCESS, then a clean transfer.
    pready_i = 1'b0;
    drive_cmd(1'b0, 32'h60, 64'h0, 8'h0);
    tick();
    drop_cmd();
    tick();
    chk("mrst_access_penable", penable_o, 1);
    rst_i = 1'b1;
    tick();
    chk("mrst_psel", psel_o, 0);
    chk("mrst_penable", penable_o, 0);
    chk("mrst_rsp_valid", rsp_valid_o, 0);
    chk("mrst_paddr", paddr_o, 0);
    rst_i    = 1'b0;
    pready_i = 1'b1;
    #1;
    chk("mrst_cmd_ready", cmd_ready_o, 1);
    drive_cmd(1'b1, 32'h70, 64'hCAFE, 8'h03);
    tick();
    drop_cmd();
    chk("post_setup_paddr", paddr_o, 64'h70);
    tick();
    chk("post_access_penable", penable_o, 1);
    tick();
    chk("post_rsp_valid", rsp_valid_o, 1);
    chk("post_rsp_err", rsp_err_o, 0);
    consume_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
